// File: rtl/ncl_pkg.sv
// ncl_pkg: shared types and dual-rail classification for the NCL wavefront sequencer
package ncl_pkg;
  localparam int RC_MAXW = 64;
  typedef enum logic [2:0] {IDLE, WAIT_ACK, WAIT_RES, OUT, WAIT_NULL, ERROR} seq_state_t;
  typedef enum logic [1:0] {RC_NULL, RC_DATA, RC_PARTIAL, RC_ILLEGAL} rail_class_t;
  // Bits at or above n are ignored, so callers zero-extend narrower rails.
  function automatic rail_class_t rail_class(input logic [RC_MAXW-1:0] t, input logic [RC_MAXW-1:0] f,
                                             input int n);
    logic any_hi, all_one, both_hi;
    any_hi = 1'b0;
    all_one = 1'b1;
    both_hi = 1'b0;
    for (int i = 0; i < RC_MAXW; i++) begin
      if (i < n) begin
        any_hi = any_hi | t[i] | f[i];
        all_one = all_one & (t[i] ^ f[i]);
        both_hi = both_hi | (t[i] & f[i]);
      end
    end
    return both_hi ? RC_ILLEGAL : all_one ? RC_DATA : any_hi ? RC_PARTIAL : RC_NULL;
  endfunction
endpackage

// File: rtl/ncl_wavefront_seq_if.sv
// ncl_wavefront_seq_if: stream ports and dual-rail NCL boundary signals of the sequencer
interface ncl_wavefront_seq_if #(parameter int WIDTH = 8);
  logic s_valid, s_ready, ko, ki, m_valid, m_ready, err;
  logic [WIDTH-1:0] s_data, dr_t, dr_f, res_t, res_f, m_data;
  modport slave (
    input s_valid, s_data, ko, res_t, res_f, m_ready,
    output s_ready, dr_t, dr_f, ki, m_valid, m_data, err
  );
  modport master (
    output s_valid, s_data, ko, res_t, res_f, m_ready,
    input s_ready, dr_t, dr_f, ki, m_valid, m_data, err
  );
endinterface

// File: rtl/ncl_wavefront_seq_sync2.sv
// sync2: two-flop synchronizer, reset to zero
module sync2 #(parameter int W = 1) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_s1, r_q;
  always_ff @(posedge clk) begin
    if (rst) {r_q, r_s1} <= '0;
    else {r_q, r_s1} <= {r_s1, i_d};
  end
  assign o_q = r_q;
endmodule

// File: rtl/ncl_wavefront_seq.sv
// ncl_wavefront_seq: drives DATA/NULL wavefronts into a dual-rail NCL pipeline and
// returns each completed result word on a synchronous valid/ready port.
module ncl_wavefront_seq
  import ncl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  ncl_wavefront_seq_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);
  seq_state_t r_state;
  rail_class_t w_cls, r_cls_d;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_dr_t, r_dr_f, r_m_data, w_rt_s, w_rf_s;
  logic r_ki, r_s_ready, r_m_valid, r_err;
  logic w_ko_s, w_done, w_null, w_wait, w_adv, w_fail;
  sync2 #(.W(1)) u_ko_sync (.clk(clk), .rst(rst), .i_d(bus.ko), .o_q(w_ko_s));
  sync2 #(.W(2 * WIDTH)) u_res_sync (.clk(clk), .rst(rst), .i_d({bus.res_t, bus.res_f}), .o_q({w_rt_s, w_rf_s}));
  assign w_cls = rail_class(RC_MAXW'(w_rt_s), RC_MAXW'(w_rf_s), WIDTH);
  // Skew filter: a classification counts only once seen on two consecutive cycles.
  assign w_done = (w_cls == RC_DATA) && (r_cls_d == RC_DATA);
  assign w_null = (w_cls == RC_NULL) && (r_cls_d == RC_NULL);
  assign w_wait = r_state inside {WAIT_ACK, WAIT_RES, WAIT_NULL};
  assign w_adv = (r_state == WAIT_ACK) ? !w_ko_s :
                 (r_state == WAIT_RES) ? w_done :
                 (r_state == WAIT_NULL) && w_null && w_ko_s;
  assign w_fail = (w_cls == RC_ILLEGAL) || (r_state == ERROR) || (w_wait && !w_adv && r_cnt == C_LAST);
  assign bus.dr_t = r_dr_t;
  assign bus.dr_f = r_dr_f;
  assign bus.ki = r_ki;
  assign bus.s_ready = r_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data = r_m_data;
  assign bus.err = r_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_dr_t <= '0;
      r_dr_f <= '0;
      r_ki <= 1'b1;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
      r_cls_d <= RC_NULL;
    end else begin
      r_cls_d <= w_cls;
      r_cnt <= w_wait ? r_cnt + CW'(1) : '0;
      if (w_fail) begin
        r_state <= ERROR;
        r_dr_t <= '0;
        r_dr_f <= '0;
        r_ki <= 1'b1;
        r_s_ready <= 1'b0;
        r_m_valid <= 1'b0;
        r_err <= 1'b1;
        r_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.s_valid && r_s_ready) begin
              r_dr_t <= bus.s_data;
              r_dr_f <= ~bus.s_data;
              r_s_ready <= 1'b0;
              r_state <= WAIT_ACK;
            end else r_s_ready <= w_ko_s;
          end
          WAIT_ACK: begin
            if (w_adv) begin
              r_state <= WAIT_RES;
              r_cnt <= '0;
            end
          end
          WAIT_RES: begin
            if (w_adv) begin
              r_m_data <= w_rt_s;
              r_m_valid <= 1'b1;
              r_dr_t <= '0;
              r_dr_f <= '0;
              r_state <= OUT;
              r_cnt <= '0;
            end
          end
          OUT: begin
            if (bus.m_ready) begin
              r_m_valid <= 1'b0;
              r_ki <= 1'b0;
              r_state <= WAIT_NULL;
            end
          end
          WAIT_NULL: begin
            if (w_adv) begin
              r_ki <= 1'b1;
              r_state <= IDLE;
              r_cnt <= '0;
            end
          end
          default: r_state <= ERROR;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ncl_wavefront_seq.sv
// tb_ncl_wavefront_seq: table-driven words through a behavioural dual-rail pipeline,
// plus illegal-rail, mid-flight reset and timeout sequences.
module tb_ncl_wavefront_seq;
  typedef struct {
    logic [7:0] d;
    int hold;
    logic [7:0] exp;
    bit skew;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int d_cnt = 0;
  int n_cnt = 0;
  int t_full = 0;
  bit md_skew = 1'b0;
  bit md_ill = 1'b0;
  logic [7:0] exp_q[$];
  vec_t vecs[5];
  always #5 clk = ~clk;
  ncl_wavefront_seq_if #(.WIDTH(8)) bus ();
  ncl_wavefront_seq_if #(.WIDTH(8)) bus2 ();
  ncl_wavefront_seq #(.WIDTH(8), .TIMEOUT(255)) dut (.clk(clk), .rst(rst), .bus(bus));
  ncl_wavefront_seq #(.WIDTH(8), .TIMEOUT(15)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: each accepted word pushes its expected result; pops on the output handshake.
  always @(negedge clk) begin
    if (bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected", 32'd1, 32'd0);
      else chk("sb_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
    end
  end

  // Pipeline model: ko follows the rails, results 10 cycles after DATA, NULL 10 cycles after ki=0.
  initial begin
    logic f0;
    bus.ko = 1'b1;
    bus.res_t = '0;
    bus.res_f = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        bus.ko = 1'b1;
        bus.res_t = '0;
        bus.res_f = '0;
        d_cnt = 0;
        n_cnt = 0;
      end else begin
        f0 = &(bus.res_t ^ bus.res_f);
        bus.ko = ~|(bus.dr_t | bus.dr_f);
        if (|(bus.dr_t | bus.dr_f)) begin
          d_cnt++;
          for (int i = 0; i < 8; i++) begin
            if (d_cnt >= 10 + (md_skew ? i : 0)) begin
              bus.res_t[i] = bus.dr_t[i];
              bus.res_f[i] = bus.dr_f[i];
            end
          end
        end else d_cnt = 0;
        if (!bus.ki) begin
          n_cnt++;
          if (n_cnt >= 10) begin
            bus.res_t = '0;
            bus.res_f = '0;
          end
        end else n_cnt = 0;
        if (md_ill) begin
          bus.res_t[3] = 1'b1;
          bus.res_f[3] = 1'b1;
        end
        if (!f0 && &(bus.res_t ^ bus.res_f)) t_full = cyc;
      end
    end
  end

  task automatic chk_reset(input string p);
    chk({p, "_dr_t"}, 32'(bus.dr_t), 32'd0);
    chk({p, "_dr_f"}, 32'(bus.dr_f), 32'd0);
    chk({p, "_ki"}, 32'(bus.ki), 32'd1);
    chk({p, "_s_ready"}, 32'(bus.s_ready), 32'd0);
    chk({p, "_m_valid"}, 32'(bus.m_valid), 32'd0);
    chk({p, "_m_data"}, 32'(bus.m_data), 32'd0);
    chk({p, "_err"}, 32'(bus.err), 32'd0);
  endtask

  task automatic send(input logic [7:0] d, input bit push);
    int n = 0;
    logic [7:0] nd = ~d;
    bus.s_valid = 1'b1;
    bus.s_data = d;
    while (!bus.s_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept_wait", 32'(bus.s_ready), 32'd1);
    tick();
    bus.s_valid = 1'b0;
    if (push) exp_q.push_back(d);
    chk("rails_t", 32'(bus.dr_t), 32'(d));
    chk("rails_f", 32'(bus.dr_f), 32'(nd));
  endtask

  task automatic run_word(input logic [7:0] d, input logic [7:0] exp, input int hold);
    int n = 0;
    send(d, 1'b1);
    while (!bus.m_valid && n < 100) begin
      tick();
      n++;
    end
    chk("m_valid_wait", 32'(bus.m_valid), 32'd1);
    chk("latency", cyc - t_full, 32'd4);
    for (int k = 0; k < hold; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data = 8'hFF;
      tick();
      chk("bp_valid", 32'(bus.m_valid), 32'd1);
      chk("bp_data", 32'(bus.m_data), 32'(exp));
      chk("bp_ki", 32'(bus.ki), 32'd1);
      chk("bp_s_ready", 32'(bus.s_ready), 32'd0);
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    chk("post_valid", 32'(bus.m_valid), 32'd0);
    chk("post_ki", 32'(bus.ki), 32'd0);
    n = 0;
    while (!bus.s_ready && n < 100) begin
      tick();
      n++;
    end
    chk("idle_ready", 32'(bus.s_ready), 32'd1);
    chk("idle_ki", 32'(bus.ki), 32'd1);
    chk("no_err", 32'(bus.err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{8'hA5, 0, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 3, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 20, 8'hFF, 1'b0};
    vecs[3] = '{8'hC3, 1, 8'hC3, 1'b1};
    vecs[4] = '{8'h5A, 0, 8'h5A, 1'b0};
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b0;
    bus2.s_valid = 1'b0;
    bus2.s_data = '0;
    bus2.m_ready = 1'b0;
    bus2.ko = 1'b1;
    bus2.res_t = '0;
    bus2.res_f = '0;
    repeat (3) tick();
    chk_reset("rst");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      md_skew = vecs[i].skew;
      run_word(vecs[i].d, vecs[i].exp, vecs[i].hold);
      md_skew = 1'b0;
    end
    // Illegal rails while waiting for the result.
    send(8'h96, 1'b0);
    repeat (6) tick();
    md_ill = 1'b1;
    n = 0;
    while (!bus.err && n < 20) begin
      tick();
      n++;
    end
    chk("ill_err", 32'(bus.err), 32'd1);
    chk("ill_dr_t", 32'(bus.dr_t), 32'd0);
    chk("ill_dr_f", 32'(bus.dr_f), 32'd0);
    chk("ill_m_valid", 32'(bus.m_valid), 32'd0);
    chk("ill_ki", 32'(bus.ki), 32'd1);
    md_ill = 1'b0;
    bus.s_valid = 1'b1;
    repeat (5) tick();
    chk("ill_s_ready", 32'(bus.s_ready), 32'd0);
    chk("ill_sticky", 32'(bus.err), 32'd1);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk_reset("rst_ill");
    rst = 1'b0;
    // Reset while in WAIT_RES, then a clean word.
    send(8'h77, 1'b0);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    chk_reset("rst_mid");
    rst = 1'b0;
    run_word(8'h3C, 8'h3C, 2);
    // Timeout on the TIMEOUT=15 instance with ko stuck high.
    bus2.s_valid = 1'b1;
    bus2.s_data = 8'h11;
    n = 0;
    while (!bus2.s_ready && n < 20) begin
      tick();
      n++;
    end
    chk("tmo_accept", 32'(bus2.s_ready), 32'd1);
    tick();
    bus2.s_valid = 1'b0;
    n = 0;
    while (!bus2.err && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_cycles", n, 32'd15);
    chk("tmo_err", 32'(bus2.err), 32'd1);
    chk("tmo_dr_t", 32'(bus2.dr_t), 32'd0);
    chk("tmo_s_ready", 32'(bus2.s_ready), 32'd0);
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
